// File: rtl/ed448_point_add.sv
// Ed448 extended-coordinate point adder with optional affine normalisation.
// All field arithmetic shares one radix-2^64 MSB-first modular multiplier.
//
// state | meaning
// IDLE  | waiting for req_valid, operands latched on acceptance
// ACK   | one-cycle req_ready pulse, busy asserted
// CALC  | unified addition program (10 multiplies, 7 add/sub)
// INV   | Z^(p-2) by square-and-multiply, then x, y, t = x*y, z = 1
// DONE  | result held on x3..z3 until res_ready
module ed448_point_add (
    input  logic         clk,
    input  logic         rst,
    input  logic [447:0] x1,
    input  logic [447:0] y1,
    input  logic [447:0] t1,
    input  logic [447:0] z1,
    input  logic [447:0] x2,
    input  logic [447:0] y2,
    input  logic [447:0] t2,
    input  logic [447:0] z2,
    output logic [447:0] x3,
    output logic [447:0] y3,
    output logic [447:0] t3,
    output logic [447:0] z3,
    input  logic         affine,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         req_busy,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam logic [447:0] P    = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [447:0] P_M2 = P - 448'd2;
    localparam logic [447:0] D_C  = P - 448'd39081;

    localparam logic [3:0] R_X1 = 4'd0,  R_Y1 = 4'd1,  R_T1 = 4'd2,  R_Z1 = 4'd3;
    localparam logic [3:0] R_X2 = 4'd4,  R_Y2 = 4'd5,  R_T2 = 4'd6,  R_Z2 = 4'd7;
    localparam logic [3:0] R_A  = 4'd8,  R_B  = 4'd9,  R_C  = 4'd10, R_D  = 4'd11;
    localparam logic [3:0] R_E  = 4'd12, R_F  = 4'd13, R_G  = 4'd14, R_H  = 4'd15;

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_CALC, S_INV, S_DONE} state_t;
    typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_COPY, OP_ONE} op_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] dst;
        logic [3:0] sa;
        logic [3:0] sb;
    } uop_t;

    function automatic uop_t mk(input op_t o, input logic [3:0] d, input logic [3:0] a,
                                input logic [3:0] b);
        return '{op: o, dst: d, sa: a, sb: b};
    endfunction

    function automatic logic [447:0] add_mod(input logic [447:0] a, input logic [447:0] b);
        logic [448:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P})
            s = s - {1'b0, P};
        return s[447:0];
    endfunction

    function automatic logic [447:0] sub_mod(input logic [447:0] a, input logic [447:0] b);
        logic [448:0] s;
        if (a >= b)
            s = {1'b0, a} - {1'b0, b};
        else
            s = {1'b0, a} + {1'b0, P} - {1'b0, b};
        return s[447:0];
    endfunction

    // acc*2^64 + a*dig, folded twice with 2^448 = 2^224 + 1, then one final subtract.
    function automatic logic [447:0] mul_step(input logic [447:0] acc, input logic [447:0] a,
                                              input logic [63:0] dig);
        logic [512:0] v;
        logic [64:0]  hi;
        logic [449:0] s;
        logic [1:0]   h2;
        logic [448:0] s2;
        v  = {1'b0, acc, 64'd0} + ({65'd0, a} * {449'd0, dig});
        hi = v[512:448];
        s  = {2'b00, v[447:0]} + {161'd0, hi, 224'd0} + {385'd0, hi};
        h2 = s[449:448];
        s2 = {1'b0, s[447:0]} + {223'd0, h2, 224'd0} + {447'd0, h2};
        if (s2 >= {1'b0, P})
            s2 = s2 - {1'b0, P};
        return s2[447:0];
    endfunction

    state_t       state, state_next;
    logic [447:0] rf [16];
    logic         aff_r;
    logic [4:0]   step;
    logic [2:0]   ip;
    logic [8:0]   ebit;
    uop_t         uop;
    logic [447:0] opa, opb;
    logic [447:0] mul_a, mul_b, mul_acc, mul_next;
    logic [2:0]   mul_cnt;
    logic         mul_active;
    logic         wr_en;
    logic [447:0] wr_data;
    logic         op_done, calc_last, inv_last;
    logic [447:0] nx, ny, nt, nz;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        req_busy   = 1'b0;
        res_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid)
                    state_next = S_ACK;
            end
            S_ACK: begin
                req_ready  = 1'b1;
                req_busy   = 1'b1;
                state_next = S_CALC;
            end
            S_CALC: begin
                req_busy = 1'b1;
                if (calc_last)
                    state_next = aff_r ? S_INV : S_DONE;
            end
            S_INV: begin
                req_busy = 1'b1;
                if (inv_last)
                    state_next = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // C starts out holding d so the d*T1*T2 product needs no constant operand port.
    always_comb begin
        uop = mk(OP_NOP, R_X1, R_X1, R_X1);
        if (state == S_CALC) begin
            case (step)
                5'd0:  uop = mk(OP_MUL, R_A,  R_X1, R_X2);
                5'd1:  uop = mk(OP_MUL, R_B,  R_Y1, R_Y2);
                5'd2:  uop = mk(OP_MUL, R_C,  R_T1, R_C);
                5'd3:  uop = mk(OP_MUL, R_C,  R_C,  R_T2);
                5'd4:  uop = mk(OP_MUL, R_D,  R_Z1, R_Z2);
                5'd5:  uop = mk(OP_ADD, R_E,  R_X1, R_Y1);
                5'd6:  uop = mk(OP_ADD, R_F,  R_X2, R_Y2);
                5'd7:  uop = mk(OP_MUL, R_E,  R_E,  R_F);
                5'd8:  uop = mk(OP_SUB, R_E,  R_E,  R_A);
                5'd9:  uop = mk(OP_SUB, R_E,  R_E,  R_B);
                5'd10: uop = mk(OP_SUB, R_F,  R_D,  R_C);
                5'd11: uop = mk(OP_ADD, R_G,  R_D,  R_C);
                5'd12: uop = mk(OP_SUB, R_H,  R_B,  R_A);
                5'd13: uop = mk(OP_MUL, R_X1, R_E,  R_F);
                5'd14: uop = mk(OP_MUL, R_Y1, R_G,  R_H);
                5'd15: uop = mk(OP_MUL, R_T1, R_E,  R_H);
                5'd16: uop = mk(OP_MUL, R_Z1, R_F,  R_G);
                default: ;
            endcase
        end else if (state == S_INV) begin
            // X2 slot is free by now and serves as the exponentiation accumulator.
            case (ip)
                3'd0: uop = mk(OP_COPY, R_X2, R_Z1, R_Z1);
                3'd1: uop = mk(OP_MUL,  R_X2, R_X2, R_X2);
                3'd2: uop = mk(OP_MUL,  R_X2, R_X2, R_Z1);
                3'd3: uop = mk(OP_MUL,  R_X1, R_X1, R_X2);
                3'd4: uop = mk(OP_MUL,  R_Y1, R_Y1, R_X2);
                3'd5: uop = mk(OP_MUL,  R_T1, R_X1, R_Y1);
                3'd6: uop = mk(OP_ONE,  R_Z1, R_Z1, R_Z1);
                default: ;
            endcase
        end
    end

    assign opa      = rf[uop.sa];
    assign opb      = rf[uop.sb];
    assign mul_next = mul_step(mul_acc, mul_a, mul_b[447:384]);

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (uop.op)
            OP_ADD:  begin wr_en = 1'b1; wr_data = add_mod(opa, opb); end
            OP_SUB:  begin wr_en = 1'b1; wr_data = sub_mod(opa, opb); end
            OP_COPY: begin wr_en = 1'b1; wr_data = opa; end
            OP_ONE:  begin wr_en = 1'b1; wr_data = 448'd1; end
            OP_MUL:  begin wr_en = mul_active && (mul_cnt == 3'd6); wr_data = mul_next; end
            default: ;
        endcase
    end

    assign op_done   = wr_en;
    assign calc_last = (state == S_CALC) && op_done && (step == 5'd16);
    assign inv_last  = (state == S_INV) && op_done && (ip == 3'd6);

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            rf[R_X1] <= x1;
            rf[R_Y1] <= y1;
            rf[R_T1] <= t1;
            rf[R_Z1] <= z1;
            rf[R_X2] <= x2;
            rf[R_Y2] <= y2;
            rf[R_T2] <= t2;
            rf[R_Z2] <= z2;
            rf[R_C]  <= D_C;
            aff_r    <= affine;
        end else if (wr_en) begin
            rf[uop.dst] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state != S_CALC && state != S_INV)) begin
            step       <= '0;
            ip         <= '0;
            ebit       <= '0;
            mul_active <= 1'b0;
            mul_cnt    <= '0;
        end else begin
            if (uop.op == OP_MUL) begin
                if (!mul_active) begin
                    mul_a      <= opa;
                    mul_b      <= opb;
                    mul_acc    <= '0;
                    mul_cnt    <= '0;
                    mul_active <= 1'b1;
                end else begin
                    mul_acc <= mul_next;
                    mul_b   <= {mul_b[383:0], 64'd0};
                    mul_cnt <= mul_cnt + 3'd1;
                    if (mul_cnt == 3'd6)
                        mul_active <= 1'b0;
                end
            end
            if (op_done) begin
                if (state == S_CALC) begin
                    step <= step + 5'd1;
                end else begin
                    case (ip)
                        3'd0: begin
                            ip   <= 3'd1;
                            ebit <= 9'd446;
                        end
                        3'd1: begin
                            if (P_M2[ebit])
                                ip <= 3'd2;
                            else if (ebit == 9'd0)
                                ip <= 3'd3;
                            else
                                ebit <= ebit - 9'd1;
                        end
                        3'd2: begin
                            if (ebit == 9'd0) begin
                                ip <= 3'd3;
                            end else begin
                                ip   <= 3'd1;
                                ebit <= ebit - 9'd1;
                            end
                        end
                        default: ip <= ip + 3'd1;
                    endcase
                end
            end
        end
    end

    // The final program write lands on the same edge as the DONE transition.
    assign nx = (wr_en && uop.dst == R_X1) ? wr_data : rf[R_X1];
    assign ny = (wr_en && uop.dst == R_Y1) ? wr_data : rf[R_Y1];
    assign nt = (wr_en && uop.dst == R_T1) ? wr_data : rf[R_T1];
    assign nz = (wr_en && uop.dst == R_Z1) ? wr_data : rf[R_Z1];

    always_ff @(posedge clk) begin
        if (rst) begin
            x3 <= '0;
            y3 <= '0;
            t3 <= '0;
            z3 <= '0;
        end else if (state != S_DONE && state_next == S_DONE) begin
            x3 <= nx;
            y3 <= ny;
            t3 <= nt;
            z3 <= nz;
        end
    end

endmodule

// File: tb/tb_ed448_point_add.sv
// Directed and randomized checks of ed448_point_add against an affine Edwards-law model.
module tb_ed448_point_add;

    localparam logic [447:0] P  = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [447:0] DC = P - 448'd39081;
    localparam logic [447:0] GX = 448'h4f1970c66bed0ded221d15a622bf36da9e146570470f1767ea6de324a3d3a46412ae1af72ab66511433b80e18b00938e2626a82bc70cc05e;
    localparam logic [447:0] GY = 448'h693f46716eb6bc248876203756c9c7624bea73736ca3984087789c1e05a0c2d73ad3ff1ce67c39c4fdbd132c4ed7c8ad9808795bf230fa14;
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         rst;
    logic [447:0] x1, y1, t1, z1, x2, y2, t2, z2;
    logic [447:0] x3, y3, t3, z3;
    logic         affine, req_valid, req_ready, req_busy, res_valid, res_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ed448_point_add dut (
        .clk(clk), .rst(rst),
        .x1(x1), .y1(y1), .t1(t1), .z1(z1),
        .x2(x2), .y2(y2), .t2(t2), .z2(z2),
        .x3(x3), .y3(y3), .t3(t3), .z3(z3),
        .affine(affine), .req_valid(req_valid), .req_ready(req_ready),
        .req_busy(req_busy), .res_valid(res_valid), .res_ready(res_ready)
    );

    function automatic logic [447:0] mm(input logic [447:0] a, input logic [447:0] b);
        logic [895:0] t;
        t = {448'd0, a} * {448'd0, b};
        t = t % {448'd0, P};
        return t[447:0];
    endfunction

    function automatic logic [447:0] madd(input logic [447:0] a, input logic [447:0] b);
        logic [448:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = s % {1'b0, P};
        return s[447:0];
    endfunction

    function automatic logic [447:0] msub(input logic [447:0] a, input logic [447:0] b);
        return madd(a, P - b);
    endfunction

    function automatic logic [447:0] minv(input logic [447:0] a);
        logic [447:0] r;
        logic [447:0] e;
        e = P - 448'd2;
        r = 448'd1;
        for (int i = 447; i >= 0; i--) begin
            r = mm(r, r);
            if (e[i])
                r = mm(r, a);
        end
        return r;
    endfunction

    function automatic logic [447:0] rnd_fe();
        logic [447:0] v;
        v = '0;
        for (int i = 0; i < 14; i++)
            v = {v[415:0], 32'($urandom())};
        if (v >= P)
            v = v - P;
        return v;
    endfunction

    // Affine Edwards addition law (a = 1).
    task automatic aff_add(input logic [447:0] ax, input logic [447:0] ay, input logic [447:0] bx,
                           input logic [447:0] by, output logic [447:0] cx, output logic [447:0] cy);
        logic [447:0] k;
        k  = mm(DC, mm(mm(ax, bx), mm(ay, by)));
        cx = mm(madd(mm(ax, by), mm(ay, bx)), minv(madd(448'd1, k)));
        cy = mm(msub(mm(ay, by), mm(ax, bx)), minv(msub(448'd1, k)));
    endtask

    task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_p1(input logic [447:0] ax, input logic [447:0] ay, input logic [447:0] z);
        x1 = mm(ax, z);
        y1 = mm(ay, z);
        t1 = mm(mm(ax, ay), z);
        z1 = z;
    endtask

    task automatic set_p2(input logic [447:0] ax, input logic [447:0] ay, input logic [447:0] z);
        x2 = mm(ax, z);
        y2 = mm(ay, z);
        t2 = mm(mm(ax, ay), z);
        z2 = z;
    endtask

    task automatic run_op(input logic aff, input int hold, input string tag);
        int cyc;
        logic [1791:0] snap;
        @(negedge clk);
        affine    = aff;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " req_ready"}, 448'(req_ready), 448'd1);
        chk({tag, " req_busy"}, 448'(req_busy), 448'd1);
        @(negedge clk);
        chk({tag, " ready_pulse"}, 448'(req_ready), 448'd0);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " res_valid"}, 448'(res_valid), 448'd1);
        chk({tag, " busy_low"}, 448'(req_busy), 448'd0);
        snap = {x3, y3, t3, z3};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, 448'(res_valid), 448'd1);
            chk({tag, " hold_stable"}, 448'({x3, y3, t3, z3} === snap), 448'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, " consumed"}, 448'(res_valid), 448'd0);
    endtask

    task automatic chk_aff(input string tag, input logic [447:0] ex, input logic [447:0] ey);
        chk({tag, " x"}, x3, ex);
        chk({tag, " y"}, y3, ey);
        chk({tag, " t"}, t3, mm(ex, ey));
        chk({tag, " z"}, z3, 448'd1);
    endtask

    task automatic chk_proj(input string tag, input logic [447:0] ex, input logic [447:0] ey);
        logic [447:0] zi;
        zi = minv(z3);
        chk({tag, " x"}, mm(x3, zi), ex);
        chk({tag, " y"}, mm(y3, zi), ey);
        chk({tag, " tz"}, mm(t3, z3), mm(x3, y3));
        chk({tag, " reduced"}, 448'((x3 < P) && (y3 < P) && (t3 < P) && (z3 < P)), 448'd1);
    endtask

    initial begin
        logic [447:0] g2x, g2y, g3x, g3y, ax, ay, bx, by, cx, cy, za, zb;
        rst = 1'b1;
        {x1, y1, t1, z1, x2, y2, t2, z2} = '0;
        affine = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 448'(req_ready), 448'd0);
        chk("reset req_busy", 448'(req_busy), 448'd0);
        chk("reset res_valid", 448'(res_valid), 448'd0);
        chk("reset x3", x3, 448'd0);
        chk("reset z3", z3, 448'd0);
        rst = 1'b0;

        set_p1(448'd0, 448'd1, 448'd1);
        set_p2(448'd0, 448'd1, 448'd1);
        run_op(1'b0, 10, "id+id");
        chk("id+id x", x3, 448'd0);
        chk("id+id y", y3, 448'd1);
        chk("id+id t", t3, 448'd0);
        chk("id+id z", z3, 448'd1);

        res_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle ready", 448'({req_ready, req_busy, res_valid}), 448'd0);
        end
        chk("idle keep", 448'({x3, y3, t3, z3} === {448'd0, 448'd1, 448'd0, 448'd1}), 448'd1);
        res_ready = 1'b0;

        aff_add(GX, GY, GX, GY, g2x, g2y);
        aff_add(GX, GY, g2x, g2y, g3x, g3y);

        set_p1(GX, GY, 448'd1);
        set_p2(448'd0, 448'd1, 448'd1);
        run_op(1'b1, 0, "G+id");
        chk_aff("G+id", GX, GY);

        set_p2(GX, GY, 448'd1);
        run_op(1'b1, 0, "G+G");
        chk_aff("G+G", g2x, g2y);

        set_p2(g2x, g2y, 448'd1);
        run_op(1'b1, 0, "G+2G");
        chk_aff("G+2G", g3x, g3y);

        set_p1(g2x, g2y, 448'd1);
        set_p2(GX, GY, 448'd1);
        run_op(1'b1, 0, "2G+G");
        chk_aff("2G+G", g3x, g3y);

        set_p1(GX, GY, 448'd1);
        set_p2(P - GX, GY, 448'd1);
        run_op(1'b1, 0, "G-G");
        chk_aff("G-G", 448'd0, 448'd1);

        set_p1(GX, GY, 448'd5);
        set_p2(GX, GY, 448'd1);
        run_op(1'b1, 0, "5G+G aff");
        chk_aff("5G+G aff", g2x, g2y);
        run_op(1'b0, 0, "5G+G proj");
        chk("5G+G proj z!=1", 448'(z3 != 448'd1), 448'd1);
        chk_proj("5G+G proj", g2x, g2y);

        for (int i = 0; i < 6; i++) begin
            ax = rnd_fe(); ay = rnd_fe(); bx = rnd_fe(); by = rnd_fe();
            za = rnd_fe(); zb = rnd_fe();
            if (za == 0) za = 448'd3;
            if (zb == 0) zb = 448'd7;
            set_p1(ax, ay, za);
            set_p2(bx, by, zb);
            aff_add(ax, ay, bx, by, cx, cy);
            run_op(1'b0, 0, $sformatf("rnd%0d", i));
            chk_proj($sformatf("rnd%0d", i), cx, cy);
        end

        ax = rnd_fe(); ay = rnd_fe(); bx = rnd_fe(); by = rnd_fe();
        set_p1(ax, ay, 448'd9);
        set_p2(bx, by, 448'd1);
        aff_add(ax, ay, bx, by, cx, cy);
        run_op(1'b1, 0, "rnd aff");
        chk_aff("rnd aff", cx, cy);

        set_p1(GX, GY, 448'd1);
        set_p2(GX, GY, 448'd1);
        @(negedge clk);
        affine    = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort busy before", 448'(req_busy), 448'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 448'(req_busy), 448'd0);
        chk("abort res_valid", 448'(res_valid), 448'd0);
        chk("abort x3", x3, 448'd0);
        rst = 1'b0;
        set_p2(448'd0, 448'd1, 448'd1);
        run_op(1'b0, 0, "after abort");
        chk_proj("after abort", GX, GY);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
